deserializer: RTL and testbench

DESERIALIZER -- requirements
Module: deserializer

---
 rtl/deser_pkg.sv | 12 +
 rtl/deserializer.sv | 64 ++++++
 tb/tb_deserializer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/deser_pkg.sv
// Shared constants for the serial-to-parallel deserializer and its downstream consumers.
package deser_pkg;

   localparam int unsigned DESER_WIDTH = 16;

   function automatic int unsigned cnt_width(input int unsigned w);
      return $clog2(w + 1);
   endfunction

   localparam int unsigned DESER_CNT_W = cnt_width(DESER_WIDTH);

endpackage

// File: rtl/deserializer.sv
// Collects WIDTH qualified serial bits and emits them as one parallel word
// with a single-cycle strobe; bit order is selectable at elaboration.
module deserializer
   import deser_pkg::*;
#(
   parameter int unsigned WIDTH     = DESER_WIDTH,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic             clk_i,
   input  logic             srst_i,
   input  logic             data_i,
   input  logic             data_val_i,
   output logic [WIDTH-1:0] deser_data_o,
   output logic             deser_data_val_o,
   output logic             busy_o
);

   localparam int unsigned CNT_W = cnt_width(WIDTH);

   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_next;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] shreg_next;
   logic             last_bit;

   // A plain shift places bit k at WIDTH-1-k (or k) once all WIDTH bits are in,
   // which is the count-indexed position without a variable-index write.
   always_comb begin
      shreg_next = shreg;
      count_next = count;
      last_bit   = 1'b0;
      if (data_val_i) begin
         shreg_next = MSB_FIRST ? {shreg[WIDTH-2:0], data_i}
                                : {data_i, shreg[WIDTH-1:1]};
         last_bit   = (count == CNT_W'(WIDTH - 1));
         count_next = last_bit ? '0 : count + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         count <= '0;
         shreg <= '0;
      end else begin
         count <= count_next;
         shreg <= shreg_next;
      end
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         deser_data_o     <= '0;
         deser_data_val_o <= 1'b0;
         busy_o           <= 1'b0;
      end else begin
         deser_data_val_o <= last_bit;
         busy_o           <= (count_next != '0);
         if (last_bit) begin
            deser_data_o <= shreg_next;
         end
      end
   end

endmodule

// File: tb/tb_deserializer.sv
// Randomized bench for deserializer: MSB-first and LSB-first instances share one
// bit stream and are checked against a queue-based word-assembly model.
module tb_deserializer;
   import deser_pkg::*;

   localparam int unsigned W = DESER_WIDTH;

   logic         clk = 1'b0;
   logic         srst;
   logic         din;
   logic         dval;
   logic [W-1:0] m_data;
   logic         m_val;
   logic         m_busy;
   logic [W-1:0] l_data;
   logic         l_val;
   logic         l_busy;

   int unsigned  n_checks = 0;
   int unsigned  n_fail   = 0;
   int unsigned  cyc      = 0;
   int unsigned  m_strobes = 0;
   int unsigned  last_strobe_cyc = 0;

   // reference model state
   bit           bitq[$];
   longint unsigned exp_m_data = 0;
   longint unsigned exp_l_data = 0;
   bit           exp_val  = 1'b0;
   bit           exp_busy = 1'b0;

   always #5 clk = ~clk;

   deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
      .clk_i           (clk),
      .srst_i          (srst),
      .data_i          (din),
      .data_val_i      (dval),
      .deser_data_o    (m_data),
      .deser_data_val_o(m_val),
      .busy_o          (m_busy)
   );

   deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
      .clk_i           (clk),
      .srst_i          (srst),
      .data_i          (din),
      .data_val_i      (dval),
      .deser_data_o    (l_data),
      .deser_data_val_o(l_val),
      .busy_o          (l_busy)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // One clock: drive inputs, let the edge happen, advance the model, compare.
   task automatic cycle(input bit rst, input bit v, input bit b);
      srst = rst;
      dval = v;
      din  = b;
      @(posedge clk);
      #1;
      cyc++;
      exp_val = 1'b0;
      if (rst) begin
         bitq.delete();
         exp_m_data = 0;
         exp_l_data = 0;
      end else if (v) begin
         bitq.push_back(b);
         if (bitq.size() == W) begin
            exp_m_data = 0;
            exp_l_data = 0;
            for (int i = 0; i < int'(W); i++) begin
               exp_m_data += longint'(bitq[i]) * (64'd1 << (W - 1 - i));
               exp_l_data += longint'(bitq[i]) * (64'd1 << i);
            end
            exp_val = 1'b1;
            bitq.delete();
         end
      end
      exp_busy = (bitq.size() != 0);
      check("msb_val",  m_val,  exp_val);
      check("msb_busy", m_busy, exp_busy);
      check("msb_data", m_data, exp_m_data);
      check("lsb_val",  l_val,  exp_val);
      check("lsb_busy", l_busy, exp_busy);
      check("lsb_data", l_data, exp_l_data);
      if (m_val) begin
         m_strobes++;
         last_strobe_cyc = cyc;
      end
   endtask

   task automatic send_word(input logic [W-1:0] word, input int unsigned max_gap);
      for (int i = int'(W) - 1; i >= 0; i--) begin
         cycle(1'b0, 1'b1, word[i]);
         if (i != 0 && max_gap != 0) begin
            int unsigned gap = $urandom_range(max_gap, 0);
            for (int g = 0; g < int'(gap); g++) cycle(1'b0, 1'b0, $urandom_range(1, 0) != 0);
         end
      end
   endtask

   initial begin
      int unsigned t1;
      int unsigned s0;

      srst = 1'b1;
      dval = 1'b0;
      din  = 1'b0;
      cycle(1'b1, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 1'b1);
      check("rst_data", m_data, 16'h0000);
      check("rst_busy", m_busy, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);

      // contiguous word, strobe on the edge sampling the last bit
      s0 = m_strobes;
      send_word(16'h0840, 0);
      check("s026_val",  m_val,  1'b1);
      check("s026_data", m_data, 16'h0840);
      cycle(1'b0, 1'b0, 1'b0);
      check("s026_one_strobe", m_strobes - s0, 1);

      // same word with idle gaps; busy is checked every cycle by the model
      s0 = m_strobes;
      send_word(16'h0840, 3);
      check("s027_data", m_data, 16'h0840);
      cycle(1'b0, 1'b0, 1'b0);
      check("s027_one_strobe", m_strobes - s0, 1);

      // back-to-back words
      send_word(16'hFFFF, 0);
      check("s028_first", m_data, 16'hFFFF);
      t1 = last_strobe_cyc;
      send_word(16'h0001, 0);
      check("s028_second", m_data, 16'h0001);
      check("s028_spacing", last_strobe_cyc - t1, W);

      // reset discards a partial word
      s0 = m_strobes;
      for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, 1'b1);
      cycle(1'b1, 1'b1, 1'b1);
      check("s029_busy_after_rst", m_busy, 1'b0);
      check("s029_no_strobe", m_strobes - s0, 0);
      send_word(16'hA5A5, 0);
      check("s029_data", m_data, 16'hA5A5);
      check("s029_one_strobe", m_strobes - s0, 1);

      // bit order: single leading one
      send_word(16'h8000, 0);
      check("s030_lsb", l_data, 16'h0001);
      check("s030_msb", m_data, 16'h8000);

      // random words, gaps, and occasional resets mid-stream
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(9, 0) == 0) begin
            for (int i = 0; i < int'($urandom_range(W - 1, 1)); i++)
               cycle(1'b0, 1'b1, $urandom_range(1, 0) != 0);
            cycle(1'b1, $urandom_range(1, 0) != 0, 1'b1);
         end
         send_word(W'($urandom), $urandom_range(2, 0));
      end
      cycle(1'b0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
